pb_gpi_irq: RTL and testbench
=============================

PB_GPI_IRQ -- requirements
Module: pb_gpi_irq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of input channels (legal 1..8).
REQ-002 Parameter DEBOUNCE, default 4, SHALL set the consecutive stable synced cycles needed to accept a new level (legal 0..255; 0 = bypass).
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n_i  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 gpi  input  WIDTH  SHALL carry the asynchronous external inputs.
REQ-006 addr  input  3  SHALL select the register.
REQ-007 wr_en  input  1  SHALL be the write strobe; a write occurs on any rising clk_i edge where it is high.
REQ-008 wr_data  input  8  SHALL carry the write data.
REQ-009 rd_data  output  8  SHALL carry the combinational read data for addr.
REQ-010 int_o  output  1  SHALL be the registered, level interrupt request.

Function
REQ-011 Register map SHALL be: 0 DATA (RO), 1 ENABLE (RW), 2 MASK (RW), 3 RISE (RW), 4 FALL (RW), 5 STATUS (RO, W1C); 6-7 read 0x00, ignore writes.
REQ-012 Bits [7:WIDTH] SHALL read 0 and ignore writes.
REQ-013 Each gpi bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per channel, the block SHALL hold a stable level and a debounce counter sized for DEBOUNCE.
REQ-015 While the synced bit equals the stable level, the counter SHALL be held at 0.
REQ-016 While they differ, the counter SHALL increment each cycle; when it reaches DEBOUNCE-1, the stable level SHALL toggle and the counter SHALL clear on the same edge.
REQ-017 A single cycle of agreement SHALL restart the count; no partial credit.
REQ-018 With DEBOUNCE=0, stable SHALL equal synced one cycle later.
REQ-019 With DEBOUNCE=N>=1, latency from a clean gpi change to DATA SHALL be 2+N cycles.
REQ-020 With ENABLE[i]=0, stable[i] and counter[i] SHALL be forced to 0.
REQ-021 With ENABLE[i]=0, channel i SHALL generate no events.
REQ-022 DATA[i] SHALL read stable[i].
REQ-023 A rising event on i SHALL be stable[i] going 0->1 with RISE[i]=1.
REQ-024 A falling event on i SHALL be stable[i] going 1->0 with FALL[i]=1.
REQ-025 RISE[i]=FALL[i]=1 SHALL mean both-edge detection.
REQ-026 An event SHALL set STATUS[i] on the edge after the stable transition.
REQ-027 STATUS bits SHALL be sticky until cleared.
REQ-028 A write to STATUS SHALL clear each bit written 1; bits written 0 are unchanged.
REQ-029 When an event and a W1C on the same bit coincide, set SHALL win (bit remains 1).
REQ-030 int_o SHALL be registered |(STATUS & MASK), one cycle after STATUS/MASK change.
REQ-031 Clearing ENABLE[i] SHALL leave STATUS[i] unchanged.
REQ-032 A stable 1->0 caused by disabling a channel SHALL NOT produce a falling event.
REQ-033 Enabling a channel whose input is high SHALL produce a rising event after debounce if RISE[i]=1.
REQ-034 Writing MASK SHALL never modify STATUS.

Reset
REQ-035 With rst_n_i low at a clock edge, the block SHALL clear synchronizers, stable levels, counters, ENABLE, MASK, RISE, FALL, STATUS and int_o to 0.
REQ-036 After reset, rd_data SHALL read 0x00 at every address.
REQ-037 Reset asserted mid-debounce SHALL abandon the count; no event SHALL follow.
REQ-038 The first event after reset SHALL require a fresh full 2+N-cycle qualification.

Verification
REQ-039 DEBOUNCE=4; ENABLE=0x01, RISE=0x01, MASK=0x01; gpi[0] 0->1 held -> DATA=0x01 at cycle 6; STATUS=0x01 at 7; int_o=1 at 8.
REQ-040 Glitch: gpi[0] high 3 cycles then low, DEBOUNCE=4 -> DATA, STATUS, int_o stay 0.
REQ-041 FALL=0x80, ENABLE=0x80, gpi[7] 1->0 after settling -> STATUS=0x80; MASK=0 -> int_o stays 0; MASK=0x80 -> int_o=1 next cycle.
REQ-042 Write STATUS=0x01 on the same edge a new rise on bit 0 sets it -> STATUS stays 0x01, int_o stays 1; a later lone W1C -> int_o=0 one cycle after.
REQ-043 gpi=0xFF, ENABLE 0xFF->0x00 with FALL=0xFF -> DATA=0x00, no STATUS bits set; re-enable with RISE=0xFF -> STATUS=0xFF.
REQ-044 Program all registers, rst_n_i low one cycle -> all reads 0x00, int_o=0; addr 6/7 read 0x00; WIDTH=4 build: DATA bits [7:4] read 0.

Source files
------------

// File: rtl/pb_gpi_irq.sv
// pb_gpi_irq: debounced general-purpose inputs with edge-triggered, maskable interrupt.
// Each channel is synchronized, debounced into a stable level, and stable-level
// transitions raise sticky STATUS bits (write-1-to-clear) that drive a level IRQ.
module pb_gpi_irq #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] gpi,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic             int_o
);

  // Counter only has to reach DEBOUNCE-1, so it needs clog2(DEBOUNCE) bits (min 1).
  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((DEBOUNCE > 0) ? DEBOUNCE - 1 : 0);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_ENABLE = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_RISE   = 3'd3;
  localparam logic [2:0] ADDR_FALL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] enable_q, enable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic             int_q, int_d;

  logic [WIDTH-1:0] wrBits;
  logic [WIDTH-1:0] statusClr;
  logic [WIDTH-1:0] riseEv, fallEv;

  assign wrBits = wr_data[WIDTH-1:0];

  // Per-channel debounce: counter runs only while synced disagrees with stable;
  // any agreement resets it, and a disabled channel is parked at zero.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (!enable_q[i]) begin
        stable_d[i] = 1'b0;
      end else if (DEBOUNCE == 0) begin
        stable_d[i] = sync2_q[i];
      end else if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Edge events compare stable against its previous value; prev is zeroed while
  // disabled so a disable-induced 1->0 never looks like a falling edge.
  always_comb begin
    prev_d    = enable_q & stable_q;
    riseEv    = enable_q & stable_q & ~prev_q & rise_q;
    fallEv    = enable_q & ~stable_q & prev_q & fall_q;
    statusClr = (wr_en && addr == ADDR_STATUS) ? wrBits : '0;
    status_d  = (status_q & ~statusClr) | riseEv | fallEv;
    int_d     = |(status_q & mask_q);
  end

  // Control register write decode; unimplemented high bits are simply not stored.
  always_comb begin
    enable_d = enable_q;
    mask_d   = mask_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    if (wr_en) begin
      case (addr)
        ADDR_ENABLE: enable_d = wrBits;
        ADDR_MASK:   mask_d   = wrBits;
        ADDR_RISE:   rise_d   = wrBits;
        ADDR_FALL:   fall_d   = wrBits;
        default: ;
      endcase
    end
  end

  // Combinational read mux, zero-extended to the 8-bit bus.
  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_DATA:   rd_data = 8'(stable_q);
      ADDR_ENABLE: rd_data = 8'(enable_q);
      ADDR_MASK:   rd_data = 8'(mask_q);
      ADDR_RISE:   rd_data = 8'(rise_q);
      ADDR_FALL:   rd_data = 8'(fall_q);
      ADDR_STATUS: rd_data = 8'(status_q);
      default:     rd_data = 8'h00;
    endcase
  end

  // All state, including the synchronizer flops, clears on synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      enable_q <= '0;
      mask_q   <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      int_q    <= 1'b0;
    end else begin
      sync1_q  <= gpi;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      enable_q <= enable_d;
      mask_q   <= mask_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      int_q    <= int_d;
    end
  end

  assign int_o = int_q;

endmodule

// File: tb/tb_pb_gpi_irq.sv
// tb_pb_gpi_irq: table-driven vectors plus hand-written multi-cycle sequences
// for pb_gpi_irq (main instance WIDTH=8/DEBOUNCE=4, second WIDTH=4/DEBOUNCE=0).
module tb_pb_gpi_irq;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [7:0] gpi;
  logic [2:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       int_o;

  logic [3:0] gpiB;
  logic [2:0] addrB;
  logic       wrB;
  logic [7:0] wdataB;
  logic [7:0] rdB;
  logic       intB;

  int nVec  = 0;
  int nMiss = 0;

  typedef struct {
    logic       rstN;
    logic [7:0] gpi;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic [7:0] expRd;
    logic       expInt;
    int         n;
  } vec_t;

  vec_t vecs[$];

  pb_gpi_irq #(.WIDTH(8), .DEBOUNCE(4)) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .gpi    (gpi),
    .addr   (addr),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .int_o  (int_o)
  );

  pb_gpi_irq #(.WIDTH(4), .DEBOUNCE(0)) dutB (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .gpi    (gpiB),
    .addr   (addrB),
    .wr_en  (wrB),
    .wr_data(wdataB),
    .rd_data(rdB),
    .int_o  (intB)
  );

  always #5 clk_i = ~clk_i;

  function automatic void addVec(logic rstN, logic [7:0] g, logic wr, logic [2:0] a,
                                 logic [7:0] wd, logic chk, logic [7:0] expRd,
                                 logic expInt, int n);
    vec_t v;
    v.rstN = rstN; v.gpi = g; v.wr = wr; v.addr = a; v.wdata = wd;
    v.chk = chk; v.expRd = expRd; v.expInt = expInt; v.n = n;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      rst_n_i = v.rstN;
      gpi     = v.gpi;
      wr_en   = v.wr;
      addr    = v.addr;
      wr_data = v.wdata;
      #1;
      if (v.chk) begin
        checkOutput($sformatf("vec%0d.%0d rd", idx, k), rd_data, v.expRd);
        checkOutput($sformatf("vec%0d.%0d int", idx, k), {7'b0, int_o}, {7'b0, v.expInt});
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wrReg(input logic [2:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic checkRd(input string name, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    checkOutput(name, rd_data, exp);
  endtask

  task automatic checkInt(input string name, input logic exp);
    checkOutput(name, {7'b0, int_o}, {7'b0, exp});
  endtask

  task automatic wrRegB(input logic [2:0] a, input logic [7:0] d);
    addrB = a; wdataB = d; wrB = 1'b1;
    tick();
    wrB = 1'b0;
  endtask

  task automatic checkRdB(input string name, input logic [2:0] a, input logic [7:0] exp);
    addrB = a;
    #1;
    checkOutput(name, rdB, exp);
  endtask

  initial begin
    rst_n_i = 1'b0; gpi = '0; addr = '0; wr_en = 1'b0; wr_data = '0;
    gpiB = '0; addrB = '0; wrB = 1'b0; wdataB = '0;

    // reset, then every address reads zero
    addVec(0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 2);
    addVec(1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 1);
    for (int a = 1; a < 8; a++) addVec(1, 8'h00, 0, 3'(a), 8'h00, 1, 8'h00, 0, 1);
    // program ENABLE/RISE/MASK for channel 0; writes to DATA and addr 6 ignored
    addVec(1, 8'h00, 1, 1, 8'h01, 0, 8'h00, 0, 1);
    addVec(1, 8'h00, 1, 3, 8'h01, 0, 8'h00, 0, 1);
    addVec(1, 8'h00, 1, 2, 8'h01, 0, 8'h00, 0, 1);
    addVec(1, 8'h00, 1, 6, 8'hFF, 0, 8'h00, 0, 1);
    addVec(1, 8'h00, 1, 0, 8'hFF, 0, 8'h00, 0, 1);
    addVec(1, 8'h00, 0, 1, 8'h00, 1, 8'h01, 0, 1);
    addVec(1, 8'h00, 0, 2, 8'h00, 1, 8'h01, 0, 1);
    addVec(1, 8'h00, 0, 3, 8'h00, 1, 8'h01, 0, 1);
    addVec(1, 8'h00, 0, 4, 8'h00, 1, 8'h00, 0, 1);
    addVec(1, 8'h00, 0, 6, 8'h00, 1, 8'h00, 0, 1);
    addVec(1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 1);
    // gpi[0] rises: DATA at cycle 6, STATUS at 7, int_o at 8
    addVec(1, 8'h01, 0, 0, 8'h00, 1, 8'h00, 0, 6);
    addVec(1, 8'h01, 0, 0, 8'h00, 1, 8'h01, 0, 1);
    addVec(1, 8'h01, 0, 5, 8'h00, 1, 8'h01, 0, 1);
    addVec(1, 8'h01, 0, 5, 8'h00, 1, 8'h01, 1, 1);
    // W1C clears STATUS, int_o drops one cycle later
    addVec(1, 8'h01, 1, 5, 8'h01, 1, 8'h01, 1, 1);
    addVec(1, 8'h01, 0, 5, 8'h00, 1, 8'h00, 1, 1);
    addVec(1, 8'h01, 0, 5, 8'h00, 1, 8'h00, 0, 1);
    // falling edge with FALL=0: DATA follows, no event
    addVec(1, 8'h00, 0, 0, 8'h00, 1, 8'h01, 0, 6);
    addVec(1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 1);
    addVec(1, 8'h00, 0, 5, 8'h00, 1, 8'h00, 0, 2);
    // 3-cycle glitch is rejected
    addVec(1, 8'h01, 0, 0, 8'h00, 1, 8'h00, 0, 3);
    addVec(1, 8'h00, 0, 0, 8'h00, 1, 8'h00, 0, 8);
    addVec(1, 8'h00, 0, 5, 8'h00, 1, 8'h00, 0, 1);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // falling event on channel 7, masked then unmasked
    gpi = 8'h80;
    wrReg(4, 8'h80);
    wrReg(2, 8'h00);
    wrReg(1, 8'h80);
    repeat (8) tick();
    checkRd("ch7 settled data", 0, 8'h80);
    checkRd("ch7 no rise event", 5, 8'h00);
    gpi = 8'h00;
    repeat (6) tick();
    checkRd("ch7 fall data", 0, 8'h00);
    checkRd("ch7 status before", 5, 8'h00);
    tick();
    checkRd("ch7 status set", 5, 8'h80);
    checkInt("ch7 masked int", 1'b0);
    repeat (2) tick();
    checkInt("ch7 masked int later", 1'b0);
    wrReg(2, 8'h80);
    checkInt("ch7 int at mask edge", 1'b0);
    checkRd("mask write keeps status", 5, 8'h80);
    tick();
    checkInt("ch7 int after mask", 1'b1);
    wrReg(5, 8'h80);
    wrReg(2, 8'h01);
    tick();
    checkRd("ch7 cleared", 5, 8'h00);
    checkInt("ch7 int cleared", 1'b0);

    // set wins over a coincident W1C
    wrReg(1, 8'h01);
    gpi = 8'h01;
    repeat (10) tick();
    checkRd("sw first status", 5, 8'h01);
    checkInt("sw first int", 1'b1);
    gpi = 8'h00;
    repeat (10) tick();
    checkRd("sw low data", 0, 8'h00);
    checkRd("sw low status", 5, 8'h01);
    gpi = 8'h01;
    repeat (6) tick();
    checkRd("sw second data", 0, 8'h01);
    wrReg(5, 8'h01);
    checkRd("sw status kept", 5, 8'h01);
    checkInt("sw int kept", 1'b1);
    tick();
    checkInt("sw int still", 1'b1);
    wrReg(5, 8'h01);
    checkRd("sw lone clear", 5, 8'h00);
    checkInt("sw int lag", 1'b1);
    tick();
    checkInt("sw int dropped", 1'b0);

    // disabling high channels makes no falling events; re-enable rises all
    wrReg(3, 8'h00);
    wrReg(4, 8'hFF);
    wrReg(2, 8'h00);
    gpi = 8'hFF;
    wrReg(1, 8'hFF);
    repeat (10) tick();
    checkRd("all high data", 0, 8'hFF);
    checkRd("all high status", 5, 8'h00);
    wrReg(1, 8'h00);
    repeat (3) tick();
    checkRd("disabled data", 0, 8'h00);
    checkRd("disabled status", 5, 8'h00);
    repeat (3) tick();
    checkRd("disabled status later", 5, 8'h00);
    wrReg(3, 8'hFF);
    wrReg(1, 8'hFF);
    repeat (4) tick();
    checkRd("reenable data", 0, 8'hFF);
    checkRd("reenable status early", 5, 8'h00);
    tick();
    checkRd("reenable status", 5, 8'hFF);

    // reset in the middle of a debounce clears everything
    wrReg(2, 8'hFF);
    repeat (2) tick();
    checkInt("pre-reset int", 1'b1);
    gpi = 8'h00;
    repeat (4) tick();
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    checkInt("post-reset int", 1'b0);
    for (int a = 0; a < 8; a++) begin
      checkRd($sformatf("post-reset addr%0d", a), 3'(a), 8'h00);
      tick();
    end
    repeat (6) tick();
    checkRd("post-reset no event", 5, 8'h00);

    // first event after reset takes the full 2+N qualification
    wrReg(1, 8'h01);
    wrReg(3, 8'h01);
    wrReg(2, 8'h01);
    gpi = 8'h01;
    repeat (5) tick();
    checkRd("fresh data early", 0, 8'h00);
    tick();
    checkRd("fresh data", 0, 8'h01);
    tick();
    checkRd("fresh status", 5, 8'h01);
    tick();
    checkInt("fresh int", 1'b1);

    // WIDTH=4, DEBOUNCE=0 instance: upper bits read 0, bypass latency is 3
    checkRdB("B reset data", 0, 8'h00);
    wrRegB(1, 8'hFF);
    checkRdB("B enable width", 1, 8'h0F);
    wrRegB(3, 8'hFF);
    wrRegB(2, 8'hFF);
    checkRdB("B addr7", 7, 8'h00);
    gpiB = 4'hF;
    repeat (2) tick();
    checkRdB("B data early", 0, 8'h00);
    tick();
    checkRdB("B data", 0, 8'h0F);
    tick();
    checkRdB("B status", 5, 8'h0F);
    checkOutput("B int early", {7'b0, intB}, 8'h00);
    tick();
    checkOutput("B int", {7'b0, intB}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
